// File: rtl/fm_stream_ctrl.sv
// FM modulation sample scheduler: phase-accumulator tick, FIFO prefill,
// gain scaling and underrun mute/count for the DDS phase-modulation input.
module fm_stream_ctrl #(
  parameter int PREFILL_TO = 4096,
  parameter int UCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [31:0]       f_sampl,
  input  logic [7:0]        gain,
  input  logic [15:0]       data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic [31:0]       fm_out,
  output logic              fm_valid,
  output logic [1:0]        state,
  output logic [UCNT_W-1:0] underrun_cnt
);

  localparam int CW = $clog2(PREFILL_TO + 1);
  localparam logic [CW-1:0] PF_LAST = CW'(PREFILL_TO - 1);
  localparam logic [UCNT_W-1:0] UC_MAX = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREF = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_UNDR = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [31:0]       acc_q, acc_d;
  logic              tick_q, tick_d;
  logic [CW-1:0]     pcnt_q, pcnt_d;
  logic              rd_q, rd_d;
  logic              val_q, val_d;
  logic [31:0]       fm_q, fm_d;
  logic [UCNT_W-1:0] uc_q, uc_d;

  logic [32:0]        sum;
  logic signed [24:0] prod;
  logic               run_ph;
  logic               full_ok;

  assign sum  = {1'b0, acc_q} + {1'b0, f_sampl};
  assign prod = $signed({{9{data_in[15]}}, data_in})
              * $signed({17'b0, gain});

  assign run_ph  = (state_q == S_RUN) || (state_q == S_UNDR);
  // Both flags set is an inconsistent FIFO; never trust it as data ready.
  assign full_ok = fifo_full & ~fifo_empty;

  always_comb begin
    state_d = state_q;
    acc_d   = 32'd0;
    tick_d  = 1'b0;
    pcnt_d  = pcnt_q;
    rd_d    = 1'b0;
    val_d   = 1'b0;
    fm_d    = fm_q;
    uc_d    = uc_q;
    if (!en) begin
      state_d = S_IDLE;
      fm_d    = 32'd0;
    end else begin
      if (run_ph) begin
        acc_d  = sum[31:0];
        tick_d = sum[32];
      end
      unique case (state_q)
        S_IDLE: begin
          state_d = S_PREF;
          pcnt_d  = '0;
        end
        S_PREF: begin
          if (full_ok) begin
            state_d = S_RUN;
          end else if (pcnt_q == PF_LAST) begin
            if (!fifo_empty) state_d = S_RUN;
          end else begin
            pcnt_d = pcnt_q + CW'(1);
          end
        end
        S_RUN: begin
          if (tick_q) begin
            val_d = 1'b1;
            if (fifo_empty) begin
              fm_d    = 32'd0;
              state_d = S_UNDR;
              if (uc_q != UC_MAX) uc_d = uc_q + UCNT_W'(1);
            end else begin
              rd_d = 1'b1;
              fm_d = {{7{prod[24]}}, prod};
            end
          end
        end
        S_UNDR: begin
          if (tick_q) begin
            val_d = 1'b1;
            fm_d  = 32'd0;
          end
          if (full_ok) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= 32'd0;
      tick_q  <= 1'b0;
      pcnt_q  <= '0;
      rd_q    <= 1'b0;
      val_q   <= 1'b0;
      fm_q    <= 32'd0;
      uc_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      tick_q  <= tick_d;
      pcnt_q  <= pcnt_d;
      rd_q    <= rd_d;
      val_q   <= val_d;
      fm_q    <= fm_d;
      uc_q    <= uc_d;
    end
  end

  assign fifo_rd      = rd_q;
  assign fm_valid     = val_q;
  assign fm_out       = fm_q;
  assign state        = state_q;
  assign underrun_cnt = uc_q;

endmodule

// File: tb/tb_fm_stream_ctrl.sv
// Randomized bench for fm_stream_ctrl against a cycle-level integer model
// of the scheduler rules, plus directed prefill/underrun/saturation scenarios.
module tb_fm_stream_ctrl;

  localparam int PF   = 16;
  localparam int UW   = 4;
  localparam int UMAX = (1 << UW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [31:0]   f_sampl;
  logic [7:0]    gain;
  logic [15:0]   data_in;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [31:0]   fm_out;
  logic          fm_valid;
  logic [1:0]    state;
  logic [UW-1:0] underrun_cnt;

  always #20 clk = ~clk;

  fm_stream_ctrl #(
    .PREFILL_TO(PF),
    .UCNT_W    (UW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .f_sampl     (f_sampl),
    .gain        (gain),
    .data_in     (data_in),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .fifo_rd     (fifo_rd),
    .fm_out      (fm_out),
    .fm_valid    (fm_valid),
    .state       (state),
    .underrun_cnt(underrun_cnt)
  );

  int n_chk = 0;
  int n_bad = 0;

  // reference model: 0 idle, 1 prefill, 2 run, 3 underrun
  int          m_st  = 0;
  longint      m_acc = 0;
  bit          m_tick = 0;
  int          m_cnt = 0;
  bit          m_rd = 0;
  bit          m_val = 0;
  logic [31:0] m_out = 0;
  int          m_uc = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_step();
    bit     emp = fifo_empty;
    bit     fok = fifo_full && !fifo_empty;
    bit     t   = m_tick;
    int     sd  = $signed(data_in);
    longint s;
    if (!rst) begin
      m_st = 0; m_acc = 0; m_tick = 0; m_cnt = 0;
      m_rd = 0; m_val = 0; m_out = 0; m_uc = 0;
      return;
    end
    m_rd  = 0;
    m_val = 0;
    if (!en) begin
      m_st = 0; m_acc = 0; m_tick = 0; m_out = 0;
      return;
    end
    if (m_st >= 2) begin
      s      = m_acc + longint'(f_sampl);
      m_tick = (s >= 64'h1_0000_0000);
      m_acc  = s % 64'h1_0000_0000;
    end else begin
      m_acc  = 0;
      m_tick = 0;
    end
    case (m_st)
      0: begin m_st = 1; m_cnt = 0; end
      1: begin
        if (fok) m_st = 2;
        else if (m_cnt == PF - 1) begin
          if (!emp) m_st = 2;
        end else m_cnt++;
      end
      2: if (t) begin
        m_val = 1;
        if (emp) begin
          m_out = 0;
          if (m_uc < UMAX) m_uc++;
          m_st = 3;
        end else begin
          m_rd  = 1;
          m_out = sd * int'(gain);
        end
      end
      default: begin
        if (t) begin m_val = 1; m_out = 0; end
        if (fok) m_st = 2;
      end
    endcase
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("state", state, m_st);
    chk("fifo_rd", fifo_rd, m_rd);
    chk("fm_valid", fm_valid, m_val);
    chk("fm_out", fm_out, m_out);
    chk("ucnt", underrun_cnt, m_uc);
  endtask

  task automatic drive(input bit r, input bit e, input logic [31:0] f,
                       input logic [7:0] g, input logic [15:0] d,
                       input bit fl, input bit em);
    rst = r; en = e; f_sampl = f; gain = g; data_in = d;
    fifo_full = fl; fifo_empty = em;
    step();
  endtask

  initial begin
    int rds;
    int k;
    logic [31:0] fr;

    repeat (3) drive(1'b0, 1'($urandom), $urandom, 8'($urandom),
                     16'($urandom), 1'($urandom), 1'($urandom));
    chk("rst_state", state, 0);
    chk("rst_fm", fm_out, 0);
    chk("rst_ucnt", underrun_cnt, 0);

    rds = 0;
    repeat (24) begin
      drive(1, 1, 32'h4000_0000, 8'd20, 16'd100, 1, 0);
      rds += int'(fifo_rd);
    end
    chk("t2_fm", fm_out, 32'h0000_07D0);
    chk("t2_state", state, 2);
    chk("t2_reads", rds, 5);

    repeat (8) drive(1, 1, 32'h4000_0000, 8'd20, 16'hFED4, 1, 0);
    chk("t3_fm", fm_out, 32'hFFFF_E890);

    repeat (6) drive(1, 1, 32'h4000_0000, 8'd20, 16'd100, 0, 1);
    chk("t4_state", state, 3);
    chk("t4_ucnt", underrun_cnt, 1);
    chk("t4_fm", fm_out, 0);
    repeat (2) drive(1, 1, 32'h4000_0000, 8'd20, 16'd100, 1, 0);
    chk("t4_back", state, 2);
    rds = 0;
    repeat (8) begin
      drive(1, 1, 32'h4000_0000, 8'd20, 16'd100, 1, 0);
      rds += int'(fifo_rd);
    end
    chk("t4_resume", rds, 2);

    drive(1, 0, 32'h4000_0000, 8'd20, 16'd100, 0, 0);
    chk("t5_idle", state, 0);
    repeat (16) drive(1, 1, 32'h4000_0000, 8'd20, 16'd100, 0, 0);
    chk("t5_pref", state, 1);
    drive(1, 1, 32'h4000_0000, 8'd20, 16'd100, 0, 0);
    chk("t5_run", state, 2);
    drive(1, 0, 32'h4000_0000, 8'd20, 16'd100, 0, 0);
    repeat (30) drive(1, 1, 32'h4000_0000, 8'd20, 16'd100, 0, 1);
    chk("t5_hold", state, 1);

    repeat (5) drive(1, 1, 32'h4000_0000, 8'd20, 16'd100, 1, 0);
    drive(1, 0, 32'h4000_0000, 8'd20, 16'd100, 1, 0);
    chk("t6_idle", state, 0);
    chk("t6_rd", fifo_rd, 0);
    chk("t6_fm", fm_out, 0);

    repeat (2) drive(1, 1, 32'hFFFF_FFFF, 8'd3, 16'd7, 1, 0);
    for (int i = 0; i < 20; i++) begin
      repeat (3) drive(1, 1, 32'hFFFF_FFFF, 8'd3, 16'd7, 0, 1);
      repeat (2) drive(1, 1, 32'hFFFF_FFFF, 8'd3, 16'd7, 1, 0);
    end
    chk("t6_sat", underrun_cnt, 4'hF);

    fr = 32'h4000_0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 4))
          0: fr = 32'd0;
          1: fr = 32'h4000_0000;
          2: fr = 32'h8000_0000;
          3: fr = 32'hFFFF_FFFF;
          default: fr = $urandom;
        endcase
      end
      k = $urandom_range(0, 7);
      drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 49) != 0),
            fr, 8'($urandom), 16'($urandom),
            (k == 4 || k == 7), (k == 5 || k == 6 || k == 7));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
